// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : Byte FIFO feeding a UART transmitter, with strobe/busy handshake,
//            occupancy reporting and sticky overflow / launch-error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  clr_flags,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  launch_err,
  output logic                  idle,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_busy
);

  localparam int                    c_DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_FULL_COUNT = c_DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   c_CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = c_CNT_ONE[DEPTH_LOG2-1:0];
  localparam logic [7:0]            c_TIMEOUT    = BUSY_TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [7:0]              r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [7:0]              r_timer;
  logic                    r_transmit;
  logic [7:0]              r_tx_byte;
  logic                    r_overflow;
  logic                    r_launch_err;

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_wr_drop;
  logic w_pop;
  logic w_load_timer;
  logic w_dec_timer;
  logic w_timeout;

  assign w_full      = (r_count == c_FULL_COUNT);
  assign w_empty     = (r_count == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign w_wr_accept = wr_en & ~w_full & ~flush;
  assign w_wr_drop   = wr_en &  w_full & ~flush;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_timer = 1'b0;
    w_dec_timer  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !uart_busy && !flush) begin
          w_pop        = 1'b1;
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_load_timer = 1'b1;
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_timer <= 8'd1) begin
          // Byte is abandoned here; the UART never accepted it.
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_dec_timer = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_timer      <= '0;
      r_transmit   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_overflow   <= 1'b0;
      r_launch_err <= 1'b0;
    end else begin
      r_transmit <= w_pop;
      if (w_pop) begin
        r_tx_byte <= r_mem[r_rd_ptr];
      end

      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if (flush) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
        case ({w_wr_accept, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end

      if (w_load_timer) begin
        r_timer <= c_TIMEOUT;
      end else if (w_dec_timer) begin
        r_timer <= r_timer - 8'd1;
      end

      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_flags) begin
        r_overflow <= 1'b0;
      end

      if (w_timeout) begin
        r_launch_err <= 1'b1;
      end else if (clr_flags) begin
        r_launch_err <= 1'b0;
      end
    end
  end

  assign full          = w_full;
  assign empty         = w_empty;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign launch_err    = r_launch_err;
  assign idle          = w_empty & (r_state == S_IDLE);
  assign uart_transmit = r_transmit;
  assign uart_tx_byte  = r_tx_byte;

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte-wide transmit buffer that sits directly upstream of the UART transmitter. Producers push bytes at full clock rate without watching the serial line. The block drains its FIFO one byte at a time, issuing a single-cycle transmit strobe and tracking the UART's transmitting flag. It reports occupancy, overflow of the buffer, and UART handshake failures.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (default 16); legal range 1..8.
BUSY_TIMEOUT, 15, cycles to wait for uart_busy to rise after a strobe before declaring a launch error; legal range 2..255.

Ports:
clk  input  1  master clock, same domain as the UART
rst  input  1  synchronous reset, active-high
wr_en  input  1  push wr_data this cycle
wr_data  input  8  byte to queue
flush  input  1  discard all queued bytes; does not abort the byte already handed to the UART
clr_flags  input  1  clear the overflow and launch_err sticky flags
full  output  1  count == 2**DEPTH_LOG2
empty  output  1  count == 0
count  output  DEPTH_LOG2+1  bytes currently queued (excludes the in-flight byte)
overflow  output  1  sticky; a write was dropped
launch_err  output  1  sticky; UART never went busy after a strobe
idle  output  1  FIFO empty and controller in S_IDLE
uart_transmit  output  1  one-cycle transmit strobe to the UART
uart_tx_byte  output  8  byte presented with the strobe
uart_busy  input  1  UART's is-transmitting flag

Behaviour:
- Reset and clock: rst is synchronous, active-high; clock is clk.
- Reset state: count=0, rd/wr pointers=0, state=S_IDLE, uart_transmit=0, uart_tx_byte=8'h00, overflow=0, launch_err=0, full=0, empty=1, idle=1. Reset mid-transfer abandons the in-flight byte. The UART finishes its frame independently.
- All outputs are registered or decoded from registers. No combinational path runs from any input to any output.
- Storage: circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth. count is a separate register.
- Write: accepted when wr_en=1 and full=0, where full is evaluated from pre-edge count. When full=1, the write is dropped and overflow is set, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- flush: sets count=0 and rd_ptr=wr_ptr. A write in the same cycle is dropped, and overflow is not set. A pop in the same cycle is suppressed. The controller state is not affected.
- clr_flags: clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Controller states:
  - S_IDLE: when count>0, uart_busy=0 and flush=0, pop the head byte into uart_tx_byte, drive uart_transmit=1 and go to S_LAUNCH.
  - S_LAUNCH: lasts exactly one cycle. On the next edge, uart_transmit=0, the timeout counter loads BUSY_TIMEOUT, and the state goes to S_WAIT_BUSY.
  - S_WAIT_BUSY: if uart_busy=1, go to S_WAIT_DONE. Otherwise decrement the counter. At 0, set launch_err, go to S_IDLE, and drop the byte (no retry).
  - S_WAIT_DONE: when uart_busy=0, go to S_IDLE.
- Strobe timing: uart_transmit is high for exactly one cycle per byte and never on consecutive cycles. uart_tx_byte is held stable from the strobe cycle until the next pop.
- Latency: a write accepted at edge E0 into an empty queue with the UART idle gives count=1 after E0. The pop and strobe are high after E1, and the UART captures at E2. Write-to-strobe is 1 cycle.
- Back-to-back bytes: the next strobe comes no earlier than 1 cycle after uart_busy is observed low in S_WAIT_DONE.
- If uart_busy is already 1 while in S_IDLE, for example after a reset, the controller holds in S_IDLE.
- idle = empty & (state==S_IDLE).

Test Plan:
- Single byte: rst, then wr 8'hA5 with UART model busy 1 cycle after strobe for 40 cycles → exactly one uart_transmit pulse, 1 cycle after the write, uart_tx_byte=8'hA5; idle=1 after busy falls.
- Burst and wrap: DEPTH_LOG2=2; write 8'h01..8'h04, then 8'h05..8'h08 as space frees → strobes carry 01..08 in order; full=1 after the 4th write; count never exceeds 4.
- Overflow: fill 16 bytes while the UART is held busy, then write 8'hFF with wr_en and a pop in the same cycle → byte dropped, overflow=1, count=15; clr_flags → overflow=0.
- Launch timeout: uart_busy tied 0, write 8'h3C → one strobe, launch_err=1 exactly BUSY_TIMEOUT+2 cycles after the write, next byte strobed afterwards.
- Flush mid-transfer: queue 5 bytes, assert flush while in S_WAIT_DONE → count=0; the in-flight byte completes; no further strobes.
- Reset mid-operation: rst during S_WAIT_BUSY with 3 bytes queued → next cycle count=0, uart_transmit=0, flags=0, state=S_IDLE.
